fifo_wr_arbiter: RTL and testbench

Round-robin burst arbiter that shares the single write port of the FIFO between NUM_REQ requesters in the write clock domain. It grants one requester at a time and forwards that requester's data as write-increment and write-data. A grant is held for up to BURST_MAX accepted beats, then the arbiter rotates priority. The block sits directly in front of the FIFO write side (W_INC, WR_DATA, FULL).

---
 rtl/fifo_wr_arbiter.sv | 127 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ requesters.
// Grant is registered, 1 cycle after request; W_INC/WR_DATA are combinational; FIFO_FULL stalls beats.
// FIFO_FULL holds the grant and beat count; the grant releases on the burst limit or when the request drops.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 2,
    parameter int BURST_MAX  = 4
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_REQ-1:0]             REQ,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  REQ_DATA,
    input  logic                           FIFO_FULL,
    output logic [NUM_REQ-1:0]             GNT,
    output logic                           W_INC,
    output logic [DATA_WIDTH-1:0]          WR_DATA,
    output logic [ID_WIDTH-1:0]            CUR_ID,
    output logic                           BUSY
);

    localparam int CNT_W = 4;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [NUM_REQ-1:0]    gnt_q, gnt_d;
    logic [ID_WIDTH-1:0]   cur_id_q, cur_id_d;
    logic [ID_WIDTH-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;

    logic                  pick_vld;
    logic [ID_WIDTH-1:0]   pick_id;
    logic                  req_g;
    logic [DATA_WIDTH-1:0] data_g;
    logic                  accept;
    logic                  release_g;
    logic [ID_WIDTH-1:0]   next_id;

    // Rotating priority search: scanning k downward lets the smallest offset from ptr win.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == (int'(ptr_q) + k) % NUM_REQ && REQ[i]) begin
                    pick_vld = 1'b1;
                    pick_id  = ID_WIDTH'(i);
                end
            end
        end
    end

    always_comb begin
        req_g  = 1'b0;
        data_g = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cur_id_q == ID_WIDTH'(i)) begin
                req_g  = REQ[i];
                data_g = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign accept    = (state_q == S_GRANT) && req_g && !FIFO_FULL;
    assign release_g = !req_g || (accept && beat_cnt_q == CNT_W'(BURST_MAX - 1));
    assign next_id   = (cur_id_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : cur_id_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        cur_id_d   = cur_id_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d    = S_GRANT;
                    gnt_d      = NUM_REQ'(1) << pick_id;
                    cur_id_d   = pick_id;
                    beat_cnt_d = '0;
                end
            end
            S_GRANT: begin
                if (release_g) begin
                    state_d    = S_IDLE;
                    gnt_d      = '0;
                    cur_id_d   = '0;
                    ptr_d      = next_id;
                    beat_cnt_d = '0;
                end else if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            cur_id_q   <= '0;
            ptr_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            cur_id_q   <= cur_id_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // The write strobe is suppressed during reset, even though the grant registers still show the old burst.
    assign W_INC   = accept && !RST;
    assign WR_DATA = (state_q == S_GRANT) ? data_g : '0;
    assign GNT     = gnt_q;
    assign CUR_ID  = cur_id_q;
    assign BUSY    = (state_q == S_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-cycle vector table plus hand-written burst sequences.
// Each requester sends words 0xA0+16*i+n, advancing n when its word is consumed.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int IW = 2;

    logic           CLK = 1'b0;
    logic           RST;
    logic [NR-1:0]  REQ;
    logic [NR*DW-1:0] REQ_DATA;
    logic           FIFO_FULL;
    logic [NR-1:0]  GNT;
    logic           W_INC;
    logic [DW-1:0]  WR_DATA;
    logic [IW-1:0]  CUR_ID;
    logic           BUSY;

    fifo_wr_arbiter #(
        .NUM_REQ   (NR),
        .DATA_WIDTH(DW),
        .ID_WIDTH  (IW),
        .BURST_MAX (4)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ      (REQ),
        .REQ_DATA (REQ_DATA),
        .FIFO_FULL(FIFO_FULL),
        .GNT      (GNT),
        .W_INC    (W_INC),
        .WR_DATA  (WR_DATA),
        .CUR_ID   (CUR_ID),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    logic [7:0] wcnt [NR] = '{default: 8'd0};

    always @(posedge CLK) begin
        for (int i = 0; i < NR; i++) begin
            if (!RST && REQ[i] && GNT[i] && !FIFO_FULL)
                wcnt[i] <= wcnt[i] + 8'd1;
        end
    end

    always_comb begin
        REQ_DATA = '0;
        for (int i = 0; i < NR; i++)
            REQ_DATA[i*DW +: DW] = 8'hA0 + 8'(16 * i) + wcnt[i];
    end

    typedef struct {
        logic          rst;
        logic [NR-1:0] req;
        logic          full;
        logic [NR-1:0] gnt;
        logic          winc;
        logic [IW-1:0] cur;
        logic          busy;
    } vec_t;

    vec_t      tbl [21];
    logic [7:0] sb [$];
    int        n_cmp = 0;
    int        n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic [NR-1:0] req, input logic full,
                        input logic [NR-1:0] e_gnt, input logic e_winc,
                        input logic [IW-1:0] e_cur, input logic e_busy);
        logic [7:0] got;
        @(negedge CLK);
        RST       = rst;
        REQ       = req;
        FIFO_FULL = full;
        #1;
        if (e_winc)
            sb.push_back(8'hA0 + 8'(16 * int'(e_cur)) + wcnt[e_cur]);
        chk("gnt",    32'(GNT),    32'(e_gnt));
        chk("w_inc",  32'(W_INC),  32'(e_winc));
        chk("cur_id", 32'(CUR_ID), 32'(e_cur));
        chk("busy",   32'(BUSY),   32'(e_busy));
        if (!e_busy)
            chk("wr_data_idle", 32'(WR_DATA), 32'd0);
        if (W_INC) begin
            chk("sb_depth", 32'(sb.size()), 32'd1);
            if (sb.size() > 0) begin
                got = sb.pop_front();
                chk("wr_data", 32'(WR_DATA), 32'(got));
            end
        end
    endtask

    initial begin
        // Single requester, drop under full, reset mid-burst
        tbl[0]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1};
        tbl[2]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1};
        tbl[3]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1};
        tbl[4]  = '{1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b1};
        tbl[5]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[6]  = '{1'b0, 4'b1000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[7]  = '{1'b0, 4'b1000, 1'b1, 4'b1000, 1'b0, 2'd3, 1'b1};
        tbl[8]  = '{1'b0, 4'b1000, 1'b1, 4'b1000, 1'b0, 2'd3, 1'b1};
        tbl[9]  = '{1'b0, 4'b0000, 1'b1, 4'b1000, 1'b0, 2'd3, 1'b1};
        tbl[10] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[11] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1};
        tbl[12] = '{1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b1};
        tbl[13] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[14] = '{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[15] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1};
        tbl[16] = '{1'b1, 4'b0010, 1'b0, 4'b0010, 1'b0, 2'd1, 1'b1};
        tbl[17] = '{1'b0, 4'b0010, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[18] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1};
        tbl[19] = '{1'b0, 4'b0000, 1'b0, 4'b0010, 1'b0, 2'd1, 1'b1};
        tbl[20] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};

        RST = 1'b1; REQ = '0; FIFO_FULL = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK); #1;
        chk("rst_gnt",   32'(GNT),    32'd0);
        chk("rst_busy",  32'(BUSY),   32'd0);
        chk("rst_cur",   32'(CUR_ID), 32'd0);
        chk("rst_w_inc", 32'(W_INC),  32'd0);

        for (int r = 0; r < 21; r++)
            step(tbl[r].rst, tbl[r].req, tbl[r].full, tbl[r].gnt, tbl[r].winc, tbl[r].cur, tbl[r].busy);

        // Backpressure on requester 2 after two beats; the count must hold across the stall
        step(1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        repeat (2) step(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1);
        repeat (5) step(1'b0, 4'b0100, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b1);
        repeat (2) step(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1);
        step(1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        step(1'b0, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd2, 1'b1);
        step(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);

        // All four requesting: order 0,1,2,3,0 with one bubble between bursts
        step(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        step(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            repeat (4) step(1'b0, 4'b1111, 1'b0, 4'(1 << (k % 4)), 1'b1, 2'(k % 4), 1'b1);
            step(1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        end
        step(1'b0, 4'b0000, 1'b0, 4'b0010, 1'b0, 2'd1, 1'b1);
        step(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);

        // Two requesters alternating 4-beat bursts
        step(1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        step(1'b0, 4'b0011, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            repeat (4) step(1'b0, 4'b0011, 1'b0, 4'(1 << (k % 2)), 1'b1, 2'(k % 2), 1'b1);
            step(1'b0, 4'b0011, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        end
        step(1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b1);
        step(1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
